// File: rtl/inst_fetch_sequencer.sv
// rtl/inst_fetch_sequencer.sv - PC/phase owner that fetches, decodes and holds one MIPS instruction per phase wrap
// Optional FETCH_ALIGN_CHECK_EN: misaligned PC yields a NOP plus misalign_fault instead of a memory read.
module inst_fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          LATCH_PHASE = 17,
  parameter int          PHASE_MAX   = 31
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        pc_load,
  input  logic [31:0] pc_load_value,
  output logic [4:0]  timehandler,
  output logic        fetch_valid,
  output logic        r_type,
  output logic        i_type,
  output logic        j_type,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shift_amount,
  output logic [5:0]  func,
  output logic [15:0] imm,
  output logic [25:0] address,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        misalign_fault,
`endif
  output logic [31:0] inst,
  output logic [31:0] inst_addr
);

  localparam logic [4:0] STALL_PHASE = 5'(LATCH_PHASE - 1);
  localparam logic [4:0] WRAP_PHASE  = 5'(PHASE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        pend_valid;
  logic [31:0] load_val;
  logic        wrap;
  logic        stall;
  logic        misalign;
  logic        capture;
  logic        fault_capture;

`ifdef FETCH_ALIGN_CHECK_EN
  assign load_val = pc_load_value;
  assign misalign = (pc[1:0] != 2'b00);
`else
  // Without the fault path the PC can never become misaligned.
  assign load_val = pc_load_value & ~32'h0000_0003;
  assign misalign = 1'b0;
`endif

  assign wrap  = (timehandler == WRAP_PHASE);
  assign stall = (timehandler == STALL_PHASE) && !fetch_valid;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  assign opcode       = inst[31:26];
  assign rs           = inst[25:21];
  assign rt           = inst[20:16];
  assign rd           = inst[15:11];
  assign shift_amount = inst[10:6];
  assign func         = inst[5:0];
  assign imm          = inst[15:0];
  assign address      = inst[25:0];

  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    fault_capture = 1'b0;
    case (state)
      IDLE: begin
        if (timehandler == 5'd0) begin
          if (misalign) begin
            state_nxt     = DONE;
            fault_capture = 1'b1;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (imem_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (wrap) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timehandler <= 5'd0;
      pc          <= RESET_PC;
      pend_pc     <= 32'd0;
      pend_valid  <= 1'b0;
      fetch_valid <= 1'b0;
      inst        <= 32'd0;
      inst_addr   <= 32'd0;
      r_type      <= 1'b0;
      i_type      <= 1'b0;
      j_type      <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_fault <= 1'b0;
`endif
    end else begin
      state <= state_nxt;

      if (!stall) timehandler <= wrap ? 5'd0 : timehandler + 5'd1;

      if (capture) begin
        inst        <= imem_rdata;
        inst_addr   <= pc;
        fetch_valid <= 1'b1;
        r_type      <= (imem_rdata[31:26] == 6'd0);
        j_type      <= (imem_rdata[31:26] == 6'd2) || (imem_rdata[31:26] == 6'd3);
        i_type      <= (imem_rdata[31:26] != 6'd0) && (imem_rdata[31:26] != 6'd2) &&
                       (imem_rdata[31:26] != 6'd3);
      end

      if (fault_capture) begin
        inst        <= 32'd0;
        inst_addr   <= pc;
        fetch_valid <= 1'b1;
        r_type      <= 1'b1;
        i_type      <= 1'b0;
        j_type      <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_fault <= 1'b1;
`endif
      end

      // A redirect arriving in the wrap cycle bypasses the pending register.
      if (wrap) begin
        fetch_valid <= 1'b0;
        pend_valid  <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_fault <= 1'b0;
`endif
        if (pc_load)         pc <= load_val;
        else if (pend_valid) pc <= pend_pc;
        else                 pc <= pc + 32'd4;
      end else if (pc_load) begin
        pend_pc    <= load_val;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/inst_fetch_sequencer.md
Name: inst_fetch_sequencer

Overview:
- Producer side of the fetch-result latch in the multi-cycle MIPS core.
- Owns the PC and the 5-bit phase counter `timehandler`.
- Issues one instruction-memory read per instruction phase, decodes the returned word into MIPS fields, and holds them stable for the downstream latch at phase LATCH_PHASE.
- Stalls the phase counter if memory has not responded in time.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- LATCH_PHASE, 17, phase at which the downstream latch captures the fields.
- PHASE_MAX, 31, last phase value; counter wraps to 0 after it.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request; held until accepted.
- imem_addr  out  32  read address (equals pc while imem_req=1).
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- pc_load  in  1  redirect strobe from a branch or jump.
- pc_load_value  in  32  redirect target.
- timehandler  out  5  phase counter.
- fetch_valid  out  1  decoded fields valid and stable.
- r_type, i_type, j_type  out  1 each  instruction class.
- opcode  out  6; rs  out  5; rt  out  5; rd  out  5; shift_amount  out  5; func  out  6; imm  out  16; address  out  26  decoded fields.
- inst  out  32  raw instruction word.
- inst_addr  out  32  PC of inst.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, state=IDLE, timehandler=0.
  - imem_req=0, fetch_valid=0.
  - All field outputs, inst and inst_addr = 0; pending redirect cleared.
  - Reset mid-transaction drops imem_req immediately. imem_rvalid is ignored in every state except WAIT.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: if timehandler==0, go to REQ.
  - REQ: imem_req=1, imem_addr=pc, both held stable. If imem_ready=1, go to WAIT; imem_req deasserts the next cycle. imem_rvalid is first legal the cycle after acceptance.
  - WAIT: on imem_rvalid, register the fields from imem_rdata, set inst_addr=pc and fetch_valid=1, go to DONE.
  - DONE: all outputs stable through phase LATCH_PHASE and until the wrap.
- Decode:
  - opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shift_amount=[10:6], func=[5:0], imm=[15:0], address=[25:0].
  - r_type = (opcode==0).
  - j_type = (opcode==2 or opcode==3).
  - i_type = otherwise. Exactly one class bit is set while fetch_valid=1.
- Phase counter:
  - Increments by 1 each cycle and wraps from PHASE_MAX to 0.
  - Stall: while timehandler==LATCH_PHASE-1 and fetch_valid==0, the counter holds. It advances on the first cycle fetch_valid==1, so the fields are valid when timehandler==LATCH_PHASE.
- Wrap cycle (timehandler==PHASE_MAX):
  - fetch_valid goes to 0 and state returns to IDLE.
  - pc becomes the pending redirect target if one is pending, otherwise pc+4 (32-bit modulo; 32'hFFFF_FFFC becomes 0).
  - The pending redirect is then cleared.
- Redirects:
  - pc_load at any phase records pc_load_value as the pending target; the last one wins.
  - A pc_load in the wrap cycle itself is used directly for the new pc.
  - The fields already fetched are not disturbed.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- With the macro:
  - Adds output misalign_fault (1 bit).
  - If pc[1:0]!=0 on entering REQ, no memory request is made. Next cycle: inst=0 (NOP, r_type=1), inst_addr=pc, misalign_fault=1, fetch_valid=1, state=DONE.
  - misalign_fault clears at the wrap and on reset.
- Without the macro: pc_load_value[1:0] is forced to 2'b00 when captured, and no fault port exists.

Test Plan:
- Reset then imem_ready=1 at phase 1, rvalid with 32'h012A4020 at phase 2:
  - imem_addr=0.
  - At phase 17: r_type=1, opcode=0, rs=9, rt=10, rd=8, shift_amount=0, func=6'h20, inst_addr=0.
- Next instruction, rdata 32'h8D090004: imem_addr=4; i_type=1, opcode=6'h23, rs=8, rt=9, imm=16'h0004.
- rdata 32'h08000010 delivered with rvalid 3 cycles after the counter reaches 16:
  - timehandler holds at 16 for those cycles.
  - Then timehandler=17 with j_type=1, address=26'h10.
- pc_load=1, pc_load_value=32'h0000_0100 at phase 5, then pc_load_value=32'h0000_0200 at phase 9: next imem_addr=32'h200.
- pc=32'hFFFF_FFFC, no redirect: after the wrap, imem_addr=0.
- rst asserted while imem_req=1 in REQ:
  - Next cycle: imem_req=0, timehandler=0, fetch_valid=0, pc=RESET_PC.
  - A later stray imem_rvalid changes no output.
